// File: rtl/button_debounce_scheduler.sv
// Multi-button debouncer: one shared debounce timer, granted to buttons round-robin.
// Define BTN_LEVEL_OUT_EN to expose the committed button levels on output port `level`.
module button_debounce_scheduler #(
    parameter int unsigned N_BTN = 4,
    parameter int unsigned CNT_W = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] button,
    output logic [N_BTN-1:0] r_edge,
    output logic [N_BTN-1:0] f_edge,
`ifdef BTN_LEVEL_OUT_EN
    output logic [N_BTN-1:0] level,
`endif
    output logic             busy
);

    localparam int unsigned     IdxW    = (N_BTN > 1) ? $clog2(N_BTN) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(N_BTN - 1);
    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

    typedef enum logic [0:0] {StIdle, StTiming} state_e;

    state_e           state_q, state_d;
    logic [N_BTN-1:0] sync1_q, sync1_d;
    logic [N_BTN-1:0] sync2_q, sync2_d;
    logic [N_BTN-1:0] stable_q, stable_d;
    logic [N_BTN-1:0] r_edge_q, r_edge_d;
    logic [N_BTN-1:0] f_edge_q, f_edge_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IdxW-1:0]  sel_q, sel_d;
    logic [IdxW-1:0]  ptr_q, ptr_d;
    logic             tgt_q, tgt_d;

    logic [N_BTN-1:0] pending;
    logic [IdxW-1:0]  grant_idx;
    logic [IdxW-1:0]  next_ptr;
    logic             do_grant, do_abort, do_commit;

    // First requester at or after start, wrapping modulo N_BTN.
    function automatic logic [IdxW-1:0] rr_pick(input logic [N_BTN-1:0] req,
                                                input logic [IdxW-1:0]  start);
        logic [IdxW-1:0] pick;
        logic [IdxW-1:0] idx;
        logic            found;
        int unsigned     j;
        pick  = start;
        found = 1'b0;
        for (int unsigned k = 0; k < N_BTN; k++) begin
            j = 32'(start) + k;
            if (j >= N_BTN) begin
                j = j - N_BTN;
            end
            idx = IdxW'(j);
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
        return pick;
    endfunction

    assign pending   = sync2_q ^ stable_q;
    assign grant_idx = rr_pick(pending, ptr_q);
    assign next_ptr  = (sel_q == LastIdx) ? '0 : sel_q + 1'b1;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state and slot events
    always_comb begin
        state_d   = state_q;
        do_grant  = 1'b0;
        do_abort  = 1'b0;
        do_commit = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (|pending) begin
                    do_grant = 1'b1;
                    state_d  = StTiming;
                end
            end
            StTiming: begin
                if (sync2_q[sel_q] != tgt_q) begin
                    do_abort = 1'b1;
                    state_d  = StIdle;
                end else if (cnt_q == CntMax) begin
                    do_commit = 1'b1;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Datapath next-state
    always_comb begin
        sync1_d  = button;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        tgt_d    = tgt_q;
        ptr_d    = ptr_q;
        r_edge_d = '0;
        f_edge_d = '0;
        if (do_grant) begin
            sel_d = grant_idx;
            tgt_d = sync2_q[grant_idx];
            cnt_d = '0;
        end else if (do_abort) begin
            ptr_d = next_ptr;
        end else if (do_commit) begin
            stable_d[sel_q] = tgt_q;
            if (tgt_q) begin
                r_edge_d[sel_q] = 1'b1;
            end else begin
                f_edge_d[sel_q] = 1'b1;
            end
            ptr_d = next_ptr;
        end else if (state_q == StTiming) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            cnt_q    <= '0;
            sel_q    <= '0;
            tgt_q    <= 1'b0;
            ptr_q    <= '0;
            r_edge_q <= '0;
            f_edge_q <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            tgt_q    <= tgt_d;
            ptr_q    <= ptr_d;
            r_edge_q <= r_edge_d;
            f_edge_q <= f_edge_d;
        end
    end

    // Outputs
    always_comb begin
        busy   = (state_q == StTiming);
        r_edge = r_edge_q;
        f_edge = f_edge_q;
`ifdef BTN_LEVEL_OUT_EN
        level  = stable_q;
`endif
    end

endmodule
